xrv1_alu_arb: RTL
=================

XRV1_ALU_ARB -- requirements
Module: xrv1_alu_arb

Interface
REQ-001 Parameter NUM_REQ_P, default 4, number of requesters sharing one ALU (2..8).
REQ-002 Parameter DATA_WIDTH_P, default 32, operand/result width.
REQ-003 Parameter ITAG_WIDTH_P, default 4, instruction tag width.
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  in  NUM_REQ_P  per-requester request valid.
REQ-007 req_ready_o  out  NUM_REQ_P  per-requester accept; at most one bit high per cycle.
REQ-008 req_opc_i  in  NUM_REQ_P*XRV_ALU_OP_WIDTH  per-requester ALU opcode.
REQ-009 req_src0_i, req_src1_i  in  NUM_REQ_P*DATA_WIDTH_P each  per-requester operands.
REQ-010 req_itag_i  in  NUM_REQ_P*ITAG_WIDTH_P  per-requester tag.
REQ-011 rsp_valid_o  out  1  response register holds a result.
REQ-012 rsp_ready_i  in  1  consumer accepts response.
REQ-013 rsp_id_o  out  $clog2(NUM_REQ_P)  index of originating requester.
REQ-014 rsp_res_o  out  DATA_WIDTH_P  ALU result; rsp_cmp_o  out  1  ALU compare result; rsp_itag_o  out  ITAG_WIDTH_P  returned tag.

Function
REQ-015 Block SHALL be a two-stage pipeline: issue register (IS) then response register (RS), ALU evaluated combinationally from IS.
REQ-016 Request i SHALL be accepted when req_valid_i[i] & req_ready_o[i]; req_ready_o is granted only when IS is empty or IS advances to RS in the same cycle.
REQ-017 Grant SHALL be round-robin: search starts at pointer ptr, first valid requester at or after ptr (modulo NUM_REQ_P) wins.
REQ-018 On a grant to index g, ptr SHALL become (g+1) mod NUM_REQ_P; with no grant ptr holds.
REQ-019 req_ready_o SHALL depend combinationally on req_valid_i and internal state only, never on req_opc/src/itag.
REQ-020 Accepted opcode, operands, tag and requester index SHALL load into IS at the accepting edge and IS becomes valid.
REQ-021 IS SHALL advance to RS when RS is empty or rsp_ready_i is high; RS captures ALU result, compare bit, tag and index.
REQ-022 Latency SHALL be exactly 2 cycles accept-to-rsp_valid_o with no backpressure; sustained throughput one op per cycle.
REQ-023 Response handshake completes on rsp_valid_o & rsp_ready_i; with rsp_ready_i low RS and all rsp_* outputs SHALL hold stable.
REQ-024 With rsp_ready_i low and both stages full, all req_ready_o SHALL be low; no data dropped or duplicated.
REQ-025 Simultaneous RS drain and IS advance SHALL occur in one cycle (RS reloads, no bubble).
REQ-026 Results SHALL return in acceptance order; no reordering across requesters.
REQ-027 Unsupported opcodes SHALL pass through with result and compare bit 0, as the ALU produces.

Reset
REQ-028 On rst_ni low, asynchronously: IS and RS invalid, ptr=0, rsp_valid_o=0, req_ready_o=0 while reset is asserted, rsp_res_o/rsp_cmp_o/rsp_itag_o/rsp_id_o=0.
REQ-029 Reset mid-operation SHALL discard in-flight IS and RS contents; no response for those ops after release.
REQ-030 First grant possible in the first cycle after rst_ni deasserts.

Structure
REQ-031 XRV_ALU_OP_WIDTH and the XRV_ALU_* opcodes SHALL come from xrv1_pkg; a packed struct xrv_alu_req_t (opc, src0, src1, itag) SHALL be added to xrv1_pkg.
REQ-032 Exactly one sub-module SHALL be instantiated: xrv1_alu, fed from IS, alu_req_i = IS valid.
REQ-033 Round-robin selection SHALL be implemented in-module, no separate arbiter module.

Verification
REQ-034 Single op: req0 SUB src0=5 src1=7 itag=3, rsp_ready=1 -> 2 cycles later rsp_valid=1, res=0xFFFFFFFE, itag=3, id=0.
REQ-035 Fairness: all 4 valid continuously from reset, rsp_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles.
REQ-036 Backpressure: rsp_ready=0 while issuing ADD 1+1 then ADD 2+2 -> rsp holds res=2, req_ready all 0 after 2nd accept; rsp_ready=1 -> res 2 then 4 on consecutive cycles.
REQ-037 Compare: req2 LTS src0=0xFFFFFFFF src1=1 -> rsp_cmp=1, id=2; LTU same operands -> rsp_cmp=0.
REQ-038 Reset mid-flight: accept 2 ops, assert rst_ni low one cycle -> rsp_valid=0 immediately, no responses after release, next grant goes to requester 0.

Source files
------------

// File: rtl/xrv1_pkg.sv
// Shared ALU definitions: opcode width, opcode encodings and the ALU request bundle.
// Compare opcodes (LTS/LTU/EQ/NE) also return the compare bit zero-extended as the result.
package xrv1_pkg;

    localparam int unsigned XRV_ALU_OP_WIDTH = 4;
    localparam int unsigned XRV_DATA_WIDTH   = 32;
    localparam int unsigned XRV_ITAG_WIDTH   = 4;

    localparam logic [XRV_ALU_OP_WIDTH-1:0] XRV_ALU_ADD = 4'h0;
    localparam logic [XRV_ALU_OP_WIDTH-1:0] XRV_ALU_SUB = 4'h1;
    localparam logic [XRV_ALU_OP_WIDTH-1:0] XRV_ALU_AND = 4'h2;
    localparam logic [XRV_ALU_OP_WIDTH-1:0] XRV_ALU_OR  = 4'h3;
    localparam logic [XRV_ALU_OP_WIDTH-1:0] XRV_ALU_XOR = 4'h4;
    localparam logic [XRV_ALU_OP_WIDTH-1:0] XRV_ALU_SLL = 4'h5;
    localparam logic [XRV_ALU_OP_WIDTH-1:0] XRV_ALU_SRL = 4'h6;
    localparam logic [XRV_ALU_OP_WIDTH-1:0] XRV_ALU_SRA = 4'h7;
    localparam logic [XRV_ALU_OP_WIDTH-1:0] XRV_ALU_LTS = 4'h8;
    localparam logic [XRV_ALU_OP_WIDTH-1:0] XRV_ALU_LTU = 4'h9;
    localparam logic [XRV_ALU_OP_WIDTH-1:0] XRV_ALU_EQ  = 4'hA;
    localparam logic [XRV_ALU_OP_WIDTH-1:0] XRV_ALU_NE  = 4'hB;

    typedef struct packed {
        logic [XRV_ALU_OP_WIDTH-1:0] opc;
        logic [XRV_DATA_WIDTH-1:0]   src0;
        logic [XRV_DATA_WIDTH-1:0]   src1;
        logic [XRV_ITAG_WIDTH-1:0]   itag;
    } xrv_alu_req_t;

endpackage

// File: rtl/xrv1_alu.sv
// Purely combinational ALU; outputs are forced to zero when no request is presented
// and for unsupported opcodes.
module xrv1_alu
    import xrv1_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_P = 32
) (
    input  logic                        alu_req_i,
    input  logic [XRV_ALU_OP_WIDTH-1:0] alu_opc_i,
    input  logic [DATA_WIDTH_P-1:0]     alu_src0_i,
    input  logic [DATA_WIDTH_P-1:0]     alu_src1_i,
    output logic [DATA_WIDTH_P-1:0]     alu_res_o,
    output logic                        alu_cmp_o
);

    localparam int unsigned ShW = $clog2(DATA_WIDTH_P);

    logic [ShW-1:0] w_shamt;

    assign w_shamt = alu_src1_i[ShW-1:0];

    always_comb begin
        alu_res_o = '0;
        alu_cmp_o = 1'b0;
        if (alu_req_i) begin
            case (alu_opc_i)
                XRV_ALU_ADD: alu_res_o = alu_src0_i + alu_src1_i;
                XRV_ALU_SUB: alu_res_o = alu_src0_i - alu_src1_i;
                XRV_ALU_AND: alu_res_o = alu_src0_i & alu_src1_i;
                XRV_ALU_OR:  alu_res_o = alu_src0_i | alu_src1_i;
                XRV_ALU_XOR: alu_res_o = alu_src0_i ^ alu_src1_i;
                XRV_ALU_SLL: alu_res_o = alu_src0_i << w_shamt;
                XRV_ALU_SRL: alu_res_o = alu_src0_i >> w_shamt;
                XRV_ALU_SRA: alu_res_o = $signed(alu_src0_i) >>> w_shamt;
                XRV_ALU_LTS: alu_cmp_o = $signed(alu_src0_i) < $signed(alu_src1_i);
                XRV_ALU_LTU: alu_cmp_o = alu_src0_i < alu_src1_i;
                XRV_ALU_EQ:  alu_cmp_o = alu_src0_i == alu_src1_i;
                XRV_ALU_NE:  alu_cmp_o = alu_src0_i != alu_src1_i;
                default: ;
            endcase
            if (alu_opc_i inside {XRV_ALU_LTS, XRV_ALU_LTU, XRV_ALU_EQ, XRV_ALU_NE}) begin
                alu_res_o = DATA_WIDTH_P'(alu_cmp_o);
            end
        end
    end

endmodule

// File: rtl/xrv1_alu_arb.sv
// Round-robin arbiter sharing one ALU between NUM_REQ_P requesters through a
// two-stage issue (IS) / response (RS) pipeline with full backpressure.
module xrv1_alu_arb
    import xrv1_pkg::*;
#(
    parameter int unsigned NUM_REQ_P    = 4,
    parameter int unsigned DATA_WIDTH_P = 32,
    parameter int unsigned ITAG_WIDTH_P = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NUM_REQ_P-1:0]                  req_valid_i,
    output logic [NUM_REQ_P-1:0]                  req_ready_o,
    input  logic [NUM_REQ_P*XRV_ALU_OP_WIDTH-1:0] req_opc_i,
    input  logic [NUM_REQ_P*DATA_WIDTH_P-1:0]     req_src0_i,
    input  logic [NUM_REQ_P*DATA_WIDTH_P-1:0]     req_src1_i,
    input  logic [NUM_REQ_P*ITAG_WIDTH_P-1:0]     req_itag_i,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic [$clog2(NUM_REQ_P)-1:0]          rsp_id_o,
    output logic [DATA_WIDTH_P-1:0]               rsp_res_o,
    output logic                                  rsp_cmp_o,
    output logic [ITAG_WIDTH_P-1:0]               rsp_itag_o
);

    localparam int unsigned IdxW = $clog2(NUM_REQ_P);

    logic                        r_is_valid;
    logic [XRV_ALU_OP_WIDTH-1:0] r_is_opc;
    logic [DATA_WIDTH_P-1:0]     r_is_src0;
    logic [DATA_WIDTH_P-1:0]     r_is_src1;
    logic [ITAG_WIDTH_P-1:0]     r_is_itag;
    logic [IdxW-1:0]             r_is_id;

    logic                        r_rs_valid;
    logic [DATA_WIDTH_P-1:0]     r_rs_res;
    logic                        r_rs_cmp;
    logic [ITAG_WIDTH_P-1:0]     r_rs_itag;
    logic [IdxW-1:0]             r_rs_id;

    logic [IdxW-1:0]             r_ptr;

    logic                        w_rs_free;
    logic                        w_is_adv;
    logic                        w_is_free;
    logic                        w_gnt_found;
    logic [IdxW-1:0]             w_gnt_idx;
    logic                        w_accept;
    logic [IdxW-1:0]             w_ptr_next;
    logic [DATA_WIDTH_P-1:0]     w_alu_res;
    logic                        w_alu_cmp;

    // (base + off) mod NUM_REQ_P; both operands are below NUM_REQ_P so one wrap suffices.
    function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base,
                                                 input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ_P) begin
            s = s - NUM_REQ_P;
        end
        return IdxW'(s);
    endfunction

    assign w_rs_free = !r_rs_valid || rsp_ready_i;
    assign w_is_adv  = r_is_valid && w_rs_free;
    assign w_is_free = !r_is_valid || w_rs_free;

    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ_P; k++) begin
            if (!w_gnt_found && req_valid_i[wrap_idx(r_ptr, k)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = wrap_idx(r_ptr, k);
            end
        end
    end

    // Ready is masked during reset so nothing is accepted while rst_ni is low.
    assign w_accept   = rst_ni && w_gnt_found && w_is_free;
    assign w_ptr_next = (w_gnt_idx == IdxW'(NUM_REQ_P - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (w_accept) begin
            req_ready_o[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr      <= '0;
            r_is_valid <= 1'b0;
            r_is_opc   <= '0;
            r_is_src0  <= '0;
            r_is_src1  <= '0;
            r_is_itag  <= '0;
            r_is_id    <= '0;
        end else if (w_accept) begin
            r_ptr      <= w_ptr_next;
            r_is_valid <= 1'b1;
            r_is_opc   <= req_opc_i[w_gnt_idx*XRV_ALU_OP_WIDTH +: XRV_ALU_OP_WIDTH];
            r_is_src0  <= req_src0_i[w_gnt_idx*DATA_WIDTH_P +: DATA_WIDTH_P];
            r_is_src1  <= req_src1_i[w_gnt_idx*DATA_WIDTH_P +: DATA_WIDTH_P];
            r_is_itag  <= req_itag_i[w_gnt_idx*ITAG_WIDTH_P +: ITAG_WIDTH_P];
            r_is_id    <= w_gnt_idx;
        end else if (w_is_adv) begin
            r_is_valid <= 1'b0;
        end
    end

    xrv1_alu #(
        .DATA_WIDTH_P (DATA_WIDTH_P)
    ) u_alu (
        .alu_req_i  (r_is_valid),
        .alu_opc_i  (r_is_opc),
        .alu_src0_i (r_is_src0),
        .alu_src1_i (r_is_src1),
        .alu_res_o  (w_alu_res),
        .alu_cmp_o  (w_alu_cmp)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rs_valid <= 1'b0;
            r_rs_res   <= '0;
            r_rs_cmp   <= 1'b0;
            r_rs_itag  <= '0;
            r_rs_id    <= '0;
        end else if (w_is_adv) begin
            r_rs_valid <= 1'b1;
            r_rs_res   <= w_alu_res;
            r_rs_cmp   <= w_alu_cmp;
            r_rs_itag  <= r_is_itag;
            r_rs_id    <= r_is_id;
        end else if (rsp_ready_i) begin
            r_rs_valid <= 1'b0;
        end
    end

    assign rsp_valid_o = r_rs_valid;
    assign rsp_res_o   = r_rs_res;
    assign rsp_cmp_o   = r_rs_cmp;
    assign rsp_itag_o  = r_rs_itag;
    assign rsp_id_o    = r_rs_id;

endmodule
